pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; next generation of the single-cycle 32-bit Adder.
//  Splits a WIDTH-bit add into STAGES carry-chained chunks, one chunk per cycle, for high fmax.
//  Uses valid/ready handshakes on both sides and reports carry, signed overflow and zero flags.
//  Serves the multi-cycle/pipelined datapath (PC+4, branch target, ALU add/sub).
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//  STAGES  4   pipeline depth = number of CHUNK=WIDTH/STAGES-bit slices; 1 <= STAGES <= WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit accepts beat this cycle (in_valid & in_ready = accept)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      0: A+B, 1: A-B (computed as A + ~B + 1)
//  out_valid  out  1      result beat presented
//  out_ready  in   1      consumer takes beat (out_valid & out_ready = handoff)
//  out_sum    out  WIDTH  result, modulo 2^WIDTH
//  out_carry  out  1      carry out of MSB (for sub: 1 = no borrow, A >= B unsigned)
//  out_ovf    out  1      signed two's-complement overflow
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  Reset (rst_n==0 at clk edge): all stage valid bits, out_valid, out_sum, flags -> 0.
//   Reset mid-operation discards every in-flight beat; no partial result ever emerges.
//  Global stall: advance = !out_valid | out_ready; in_ready = advance (combinational).
//   On advance every stage register shifts one stage; when !advance all registers hold.
//   Bubbles (invalid stages) shift too: no bubble collapsing; throughput 1 beat/cycle.
//  Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1
//   (exactly STAGES cycles, counting the accepting cycle) when never stalled.
//  Stage i (0..STAGES-1): adds chunk i of A and B' (B' = in_sub ? ~B : B) + carry from
//   stage i-1 (stage 0 carry-in = in_sub). Registers: sum chunks 0..i, carry out of chunk i,
//   unprocessed upper chunks of A and B' (skew registers), valid bit, and sign info for ovf.
//  Flags are computed in the last stage from registered MSB data:
//   out_carry = carry out of chunk STAGES-1; out_ovf = (A[msb]==B'[msb]) & (sum[msb]!=A[msb]);
//   out_zero = ~|out_sum. All outputs are registered; none depend combinationally on inputs
//   except in_ready.
//  out_sum/flags hold stable while out_valid & !out_ready (AXI-style stability rule).
//  Data beats are never dropped or duplicated; order is strictly preserved.
//  Boundary: 0xFFFFFFFF+1 -> sum 0, carry 1, zero 1, ovf 0; 0x7FFFFFFF+1 -> ovf 1.
//   STAGES==1 degenerates to a registered single-cycle adder with the same handshake.
//  in_valid & !in_ready: beat not taken; the source must hold it (not checked by this unit).
// STRUCTURE
//  adder_pkg: localparams OP_ADD=1'b0, OP_SUB=1'b1; function chunk_width(WIDTH,STAGES).
//  Sub-module adder_stage (params CHUNK): combinational CHUNK-bit add with carry in/out,
//   instantiated STAGES times via generate; pipeline/skew registers live in pipelined_adder.
// TESTING (WIDTH=32, STAGES=4 unless noted; out_ready=1 unless noted)
//  1 Back-to-back: 1000000+2000000, 2000000+10000000, 25000000+2200000 on consecutive
//    cycles -> 3000000, 12000000, 27200000 on consecutive cycles, 4 cycles latency, flags 0.
//  2 Sub: 5-7 -> 0xFFFFFFFE carry 0; 7-5 -> 2 carry 1; 0x80000000-1 -> 0x7FFFFFFF ovf 1.
//  3 Boundary: 0xFFFFFFFF+1 -> 0, carry 1, zero 1; 0x7FFFFFFF+1 -> 0x80000000 ovf 1.
//  4 Backpressure: out_ready=0 for 6 cycles with 5 beats fed -> in_ready drops once full,
//    out_sum held stable, all 5 results later emerge in order with no loss/duplication.
//  5 Reset mid-flight: 3 beats in, rst_n=0 one cycle -> out_valid=0, no stale beat emerges;
//    next beat 1+1 -> 2 after exactly 4 cycles.
//  6 Random 10k beats, STAGES in {1,2,8}, random in_valid/out_ready -> scoreboard vs A±B model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-chained slice of the pipelined adder: purely combinational CHUNK-bit add.
module adder_stage #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage, global-stall handshake,
// carry / signed-overflow / zero flags registered alongside the result.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_adder: STAGES must lie in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  // Per-stage registers; a_q/b_q carry the not-yet-added upper chunks (B already inverted).
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [STAGES-1:0]            carry_q, valid_q;
  logic                         ovf_q, zero_q;

  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in, sum_d;
  logic [STAGES-1:0]            cin, cout, valid_in;
  logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
  logic                         ovf_d, zero_d;
  logic                         advance;

  assign advance  = ~valid_q[LAST] | out_ready;
  assign in_ready = advance;

  always_comb begin
    a_in     = '0;
    b_in     = '0;
    cin      = '0;
    sum_in   = '0;
    valid_in = '0;
    a_in[0]     = in_a;
    b_in[0]     = (in_sub == OP_SUB) ? ~in_b : in_b;
    cin[0]      = in_sub;
    valid_in[0] = in_valid;
    for (int unsigned i = 1; i < STAGES; i++) begin
      a_in[i]     = a_q[i-1];
      b_in[i]     = b_q[i-1];
      cin[i]      = carry_q[i-1];
      sum_in[i]   = sum_q[i-1];
      valid_in[i] = valid_q[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .a   (a_in[g][g*CHUNK +: CHUNK]),
      .b   (b_in[g][g*CHUNK +: CHUNK]),
      .cin (cin[g]),
      .sum (chunk_sum[g]),
      .cout(cout[g])
    );
  end

  always_comb begin
    sum_d = sum_in;
    for (int unsigned i = 0; i < STAGES; i++) begin
      sum_d[i][i*CHUNK +: CHUNK] = chunk_sum[i];
    end
  end

  // Flags only matter once the last chunk is added; operand MSBs sit in the last skew slot.
  assign ovf_d  = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &
                  (sum_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
  assign zero_d = ~|sum_d[LAST];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      a_q     <= a_in;
      b_q     <= b_in;
      sum_q   <= sum_d;
      carry_q <= cout;
      valid_q <= valid_in;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_carry = carry_q[LAST];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  // The final skew slot has nothing left to add.
  logic unused_skew;
  assign unused_skew = ^{a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: table vectors, backpressure and reset sequences on a 4-stage
// instance, plus randomized handshake traffic on 1/2/8-stage instances.
module tb_pipelined_adder;

  localparam int DSTAGES  = 4;
  localparam int NBEATS   = 10000;
  localparam int RAND_CYC = 50000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  typedef struct {
    logic [34:0] exp;
    int          acc;
    bit          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sub, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, out_carry, out_ovf, out_zero;
  logic [31:0] out_sum;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nbeat = 0;
  bit   rand_go = 1'b0;
  bit   bp_done;
  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t tv[14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(
    .WIDTH (32),
    .STAGES(DSTAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Independent reference: signed range test for overflow, unsigned compare for borrow.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    longint      sa, sb, r;
    logic [32:0] u;
    logic [31:0] s;
    logic        c, v;
    sa = $signed(a);
    sb = $signed(b);
    r  = sub ? sa - sb : sa + sb;
    v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    s  = r[31:0];
    if (sub) c = (a >= b);
    else begin
      u = {1'b0, a} + {1'b0, b};
      c = u[32];
    end
    return {s, c, v, s == 32'd0};
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Offer one beat and hold it until taken; the expectation is queued at the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [34:0] exp, input bit push, input bit lat);
    int  n;
    bit  taken;
    sb_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    n        = 0;
    taken    = 1'b0;
    while (!taken && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          e.exp = exp;
          e.acc = cyc + 1;
          e.lat = lat;
          sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        taken = 1'b1;
      end
      n++;
    end
    if (!taken) fail("send_timeout", $sformatf("beat %0h/%0h never accepted", a, b));
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(name, sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        fail("unexpected_beat", $sformatf("got sum %0h expected no beat", out_sum));
      end else begin
        mon_e = sbq.pop_front();
        nbeat++;
        chk($sformatf("beat%0d", nbeat), {out_sum, out_carry, out_ovf, out_zero}, mon_e.exp);
        if (mon_e.lat) chk($sformatf("lat%0d", nbeat), cyc - mon_e.acc, DSTAGES - 1);
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    logic        rv, rs, ro, rir, rov, rc, rvf, rz;
    logic [31:0] ra, rb, rsum;
    logic [34:0] q[$];
    logic [34:0] e;
    int          sent, rcvd;
    bit          took, done;

    pipelined_adder #(
      .WIDTH (32),
      .STAGES(S)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (rv),
      .in_ready (rir),
      .in_a     (ra),
      .in_b     (rb),
      .in_sub   (rs),
      .out_valid(rov),
      .out_ready(ro),
      .out_sum  (rsum),
      .out_carry(rc),
      .out_ovf  (rvf),
      .out_zero (rz)
    );

    initial begin
      rv = 1'b0; ra = '0; rb = '0; rs = 1'b0; ro = 1'b1;
      sent = 0; rcvd = 0; took = 1'b0; done = 1'b0;
      wait (rand_go);
      @(posedge clk);
      #1;
      for (int n = 0; n < RAND_CYC && rcvd < NBEATS; n++) begin
        if (!rv || took) begin
          took = 1'b0;
          if (sent < NBEATS && $urandom_range(0, 3) != 0) begin
            rv = 1'b1;
            ra = rnd();
            rb = rnd();
            rs = 1'($urandom_range(0, 1));
          end else begin
            rv = 1'b0;
          end
        end
        ro = ($urandom_range(0, 4) != 0);
        @(posedge clk);
        #1;
      end
      chk($sformatf("rand_s%0d_count", S), rcvd, NBEATS);
      rv   = 1'b0;
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (rv && rir) begin
          q.push_back(model(ra, rb, rs));
          sent++;
          took = 1'b1;
        end
        if (rov && ro) begin
          if (q.size() == 0) begin
            fail($sformatf("rand_s%0d_extra", S), $sformatf("got sum %0h expected no beat", rsum));
          end else begin
            e = q.pop_front();
            rcvd++;
            chk($sformatf("rand_s%0d_beat%0d", S, rcvd), {rsum, rc, rvf, rz}, e);
          end
        end
      end
    end
  end

  initial begin
    int w;
    tv[0]  = '{32'd1000000,    32'd2000000,  1'b0, 32'd3000000,    1'b0, 1'b0, 1'b0};
    tv[1]  = '{32'd2000000,    32'd10000000, 1'b0, 32'd12000000,   1'b0, 1'b0, 1'b0};
    tv[2]  = '{32'd25000000,   32'd2200000,  1'b0, 32'd27200000,   1'b0, 1'b0, 1'b0};
    tv[3]  = '{32'd5,          32'd7,        1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0};
    tv[4]  = '{32'd7,          32'd5,        1'b1, 32'd2,          1'b1, 1'b0, 1'b0};
    tv[5]  = '{32'h8000_0000,  32'd1,        1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0};
    tv[6]  = '{32'hFFFF_FFFF,  32'd1,        1'b0, 32'd0,          1'b1, 1'b0, 1'b1};
    tv[7]  = '{32'h7FFF_FFFF,  32'd1,        1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0};
    tv[8]  = '{32'd0,          32'd0,        1'b0, 32'd0,          1'b0, 1'b0, 1'b1};
    tv[9]  = '{32'd5,          32'd5,        1'b1, 32'd0,          1'b1, 1'b0, 1'b1};
    tv[10] = '{32'h8000_0000,  32'h8000_0000, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1};
    tv[11] = '{32'h0000_00FF,  32'd1,        1'b0, 32'h0000_0100,  1'b0, 1'b0, 1'b0};
    tv[12] = '{32'h00FF_FFFF,  32'd1,        1'b0, 32'h0100_0000,  1'b0, 1'b0, 1'b0};
    tv[13] = '{32'd0,          32'd1,        1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_flags", {out_carry, out_ovf, out_zero}, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table beats, latency checked on every one.
    for (int i = 0; i < 14; i++) begin
      send(tv[i].a, tv[i].b, tv[i].sub, {tv[i].sum, tv[i].c, tv[i].v, tv[i].z}, 1'b1, 1'b1);
    end
    drain("drain_table");

    // Backpressure: 5 beats offered into a stalled 4-deep pipe.
    out_ready = 1'b0;
    bp_done   = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send(32'(100 * (i + 1)), 32'd3, 1'b0, {32'(100 * (i + 1) + 3), 3'b000}, 1'b1, 1'b0);
        end
        bp_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_hold%0d", i), out_sum, 103);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    w = 0;
    while (!bp_done && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("bp_sent_all", bp_done, 1);
    drain("drain_bp");

    // Reset with three beats in flight; none may surface afterwards.
    for (int i = 0; i < 3; i++) send(32'd10 + 32'(i), 32'd20, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_sum", out_sum, 0);
    rst_n = 1'b1;
    send(32'd1, 32'd1, 1'b0, {32'd2, 3'b000}, 1'b1, 1'b1);
    drain("drain_rst");
    repeat (8) @(posedge clk);
    #1;

    rand_go = 1'b1;
    w = 0;
    while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && w < RAND_CYC + 1000) begin
      @(posedge clk);
      w++;
    end
    if (!(g_rand[0].done && g_rand[1].done && g_rand[2].done)) begin
      fail("rand_timeout", "random traffic did not complete");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
